// File: rtl/pupil_search_pkg.sv
// -----------------------------------------------------------------------------
// pupil_search_pkg
// Shared definitions for the pupil template-search controller:
//   - COORD_W / SCORE_W : coordinate (13-bit) and score (32-bit) widths
//   - state_t           : search FSM state encoding
//   - is_better()       : best-candidate replacement rule (strict greater,
//                         first candidate always loads)
// -----------------------------------------------------------------------------
package pupil_search_pkg;

    localparam int COORD_W = 13;
    localparam int SCORE_W = 32;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Ties never replace the best, so the first maximum in raster order wins.
    function automatic logic is_better(input score_t cand, input score_t best,
                                       input logic first);
        return first || (cand > best);
    endfunction

endpackage

// File: rtl/pupil_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// pupil_search_ctrl_if
// Launch/complete handshake between the search controller and the scorer.
//   oStart  : one-cycle launch pulse (controller -> scorer)
//   oXstart : candidate window X origin (controller -> scorer)
//   oYstart : candidate window Y origin (controller -> scorer)
//   iDone   : scorer-finished pulse (scorer -> controller)
//   iScore  : scorer result, valid with iDone (scorer -> controller)
// Modports: master = controller side, slave = scorer side.
// -----------------------------------------------------------------------------
interface pupil_search_ctrl_if;
    import pupil_search_pkg::*;

    logic   oStart;
    coord_t oXstart;
    coord_t oYstart;
    logic   iDone;
    score_t iScore;

    modport master (output oStart, output oXstart, output oYstart,
                    input  iDone,  input  iScore);
    modport slave  (input  oStart, input  oXstart, input  oYstart,
                    output iDone,  output iScore);
endinterface

// File: rtl/pupil_pos_gen.sv
// -----------------------------------------------------------------------------
// pupil_pos_gen
// Raster-order candidate origin generator.
//   iCLK, iRST : clock, synchronous active-high reset
//   i_clear    : restart at (0,0)
//   i_advance  : step to the next candidate (X first, then Y)
//   o_x, o_y   : current candidate origin (registered)
//   o_last     : current origin is the final candidate of the scan
// Coordinates never exceed IMG_W-TPL_W / IMG_H-TPL_H.
// -----------------------------------------------------------------------------
module pupil_pos_gen
    import pupil_search_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int TPL_W = 64,
    parameter int TPL_H = 64,
    parameter int STEP  = 4
) (
    input  logic   iCLK,
    input  logic   iRST,
    input  logic   i_clear,
    input  logic   i_advance,
    output coord_t o_x,
    output coord_t o_y,
    output logic   o_last
);

    localparam logic [COORD_W:0] X_MAX    = (COORD_W+1)'(IMG_W - TPL_W);
    localparam logic [COORD_W:0] Y_MAX    = (COORD_W+1)'(IMG_H - TPL_H);
    localparam logic [COORD_W:0] STEP_EXT = (COORD_W+1)'(STEP);

    coord_t           r_x;
    coord_t           r_y;
    logic [COORD_W:0] w_x_sum;
    logic [COORD_W:0] w_y_sum;

    // One extra bit so the "next step would overshoot" test cannot wrap.
    assign w_x_sum = {1'b0, r_x} + STEP_EXT;
    assign w_y_sum = {1'b0, r_y} + STEP_EXT;

    // Last candidate: neither axis can take another step.
    assign o_last = (w_x_sum > X_MAX) && (w_y_sum > Y_MAX);
    assign o_x    = r_x;
    assign o_y    = r_y;

    // Origin registers: X steps until it would overshoot, then wraps and Y steps.
    always_ff @(posedge iCLK) begin
        if (iRST || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_sum <= X_MAX) begin
                r_x <= w_x_sum[COORD_W-1:0];
            end else begin
                r_x <= '0;
                if (w_y_sum <= Y_MAX) begin
                    r_y <= w_y_sum[COORD_W-1:0];
                end else begin
                    r_y <= '0;
                end
            end
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

endmodule

// File: rtl/pupil_search_ctrl.sv
// -----------------------------------------------------------------------------
// pupil_search_ctrl
// Scans template candidate windows in raster order, launches the external
// scorer for each one and keeps the best (highest, first-wins) score.
//   iCLK, iRST        : clock, synchronous active-high reset
//   iGo               : start-search pulse (honoured only in IDLE)
//   iAbort            : cancel the search in progress (beats iDone)
//   iThreshold        : early-exit score threshold
//   bus (master)      : oStart/oXstart/oYstart out, iDone/iScore in
//   oBusy             : search in progress
//   oDone             : one-cycle search-complete pulse
//   oBestX/oBestY     : origin of the best candidate
//   oBestScore        : best score found
// Build option: define PUPIL_SEARCH_EARLY_EXIT_EN to finish the scan as soon
// as a captured score reaches iThreshold; otherwise iThreshold is ignored.
// -----------------------------------------------------------------------------
module pupil_search_ctrl
    import pupil_search_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int TPL_W = 64,
    parameter int TPL_H = 64,
    parameter int STEP  = 4
) (
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic                       iGo,
    input  logic                       iAbort,
    input  score_t                     iThreshold,
    pupil_search_ctrl_if.master        bus,
    output logic                       oBusy,
    output logic                       oDone,
    output coord_t                     oBestX,
    output coord_t                     oBestY,
    output score_t                     oBestScore
);

    state_t r_state;
    state_t w_next;
    logic   r_start;
    logic   r_busy;
    logic   r_done;
    logic   r_first;
    score_t r_score;
    coord_t r_best_x;
    coord_t r_best_y;
    score_t r_best_score;

    logic   w_clear;
    logic   w_advance;
    logic   w_capture;
    logic   w_load;
    logic   w_exit;
    logic   w_last;
    coord_t w_x;
    coord_t w_y;

    pupil_pos_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .TPL_W (TPL_W),
        .TPL_H (TPL_H),
        .STEP  (STEP)
    ) u_pos_gen (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .i_clear   (w_clear),
        .i_advance (w_advance),
        .o_x       (w_x),
        .o_y       (w_y),
        .o_last    (w_last)
    );

`ifdef PUPIL_SEARCH_EARLY_EXIT_EN
    assign w_exit = w_last || (r_score >= iThreshold);
`else
    logic w_thr_unused;
    assign w_thr_unused = ^iThreshold;
    assign w_exit       = w_last;
`endif

    // Next-state and datapath strobes; abort pre-empts every non-IDLE state.
    always_comb begin
        w_next    = r_state;
        w_clear   = 1'b0;
        w_advance = 1'b0;
        w_capture = 1'b0;
        w_load    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iGo) begin
                    w_next  = ST_LAUNCH;
                    w_clear = 1'b1;
                end else begin
                    w_next  = ST_IDLE;
                end
            end
            ST_LAUNCH: begin
                if (iAbort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iAbort) begin
                    w_next = ST_IDLE;
                end else if (bus.iDone) begin
                    w_next    = ST_UPDATE;
                    w_capture = 1'b1;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_UPDATE: begin
                if (iAbort) begin
                    w_next = ST_IDLE;
                end else begin
                    w_load = is_better(r_score, r_best_score, r_first);
                    if (w_exit) begin
                        w_next = ST_DONE;
                    end else begin
                        w_next    = ST_LAUNCH;
                        w_advance = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs derived from the next state.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= (w_next == ST_LAUNCH);
            r_busy  <= (w_next == ST_LAUNCH) || (w_next == ST_WAIT) ||
                       (w_next == ST_UPDATE);
            r_done  <= (w_next == ST_DONE);
        end
    end

    // Scorer result capture.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_score <= '0;
        end else if (w_capture) begin
            r_score <= bus.iScore;
        end else begin
            r_score <= r_score;
        end
    end

    // Best-candidate tracking; r_first forces the first candidate to load.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_first      <= 1'b0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_score <= '0;
        end else if (w_clear) begin
            r_first      <= 1'b1;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_score <= '0;
        end else if (w_load) begin
            r_first      <= 1'b0;
            r_best_x     <= w_x;
            r_best_y     <= w_y;
            r_best_score <= r_score;
        end else begin
            r_first      <= r_first;
            r_best_x     <= r_best_x;
            r_best_y     <= r_best_y;
            r_best_score <= r_best_score;
        end
    end

    assign bus.oStart  = r_start;
    assign bus.oXstart = w_x;
    assign bus.oYstart = w_y;
    assign oBusy       = r_busy;
    assign oDone       = r_done;
    assign oBestX      = r_best_x;
    assign oBestY      = r_best_y;
    assign oBestScore  = r_best_score;

endmodule

// File: tb/tb_pupil_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pupil_search_ctrl
// Directed bench for pupil_search_ctrl with a 16x12 image, 8x8 template and
// stride 4 (six candidates). Inputs change and outputs are sampled on the
// falling clock edge. Expectations for the early-exit scenario follow
// PUPIL_SEARCH_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_pupil_search_ctrl;
    import pupil_search_pkg::*;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iGo;
    logic        iAbort;
    logic [31:0] iThreshold;
    logic        oBusy;
    logic        oDone;
    logic [12:0] oBestX;
    logic [12:0] oBestY;
    logic [31:0] oBestScore;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [12:0] exp_x  [6] = '{13'd0, 13'd4, 13'd8, 13'd0, 13'd4, 13'd8};
    logic [12:0] exp_y  [6] = '{13'd0, 13'd0, 13'd0, 13'd4, 13'd4, 13'd4};
    logic [31:0] scores [6] = '{32'd10, 32'd50, 32'd30, 32'd50, 32'd20, 32'd5};

    pupil_search_ctrl_if bus ();

    pupil_search_ctrl #(
        .IMG_W (16), .IMG_H (12), .TPL_W (8), .TPL_H (8), .STEP (4)
    ) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iGo        (iGo),
        .iAbort     (iAbort),
        .iThreshold (iThreshold),
        .bus        (bus),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oBestX     (oBestX),
        .oBestY     (oBestY),
        .oBestScore (oBestScore)
    );

    always #5 iCLK = ~iCLK;

    // Look for oStart at the current falling edge, then up to 50 more.
    task automatic wait_start(output bit ok, output logic [12:0] x, output logic [12:0] y);
        ok = 1'b0; x = 13'd0; y = 13'd0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (bus.oStart === 1'b1) begin
                ok = 1'b1; x = bus.oXstart; y = bus.oYstart;
            end else begin
                @(negedge iCLK);
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (oDone === 1'b1) ok = 1'b1;
            else @(negedge iCLK);
        end
    endtask

    // Called in the LAUNCH cycle; returns in the UPDATE cycle.
    task automatic give_score(input logic [31:0] s, input int delay);
        @(negedge iCLK);
        repeat (delay) @(negedge iCLK);
        bus.iDone = 1'b1; bus.iScore = s;
        @(negedge iCLK);
        bus.iDone = 1'b0; bus.iScore = 32'd0;
    endtask

    task automatic pulse_go();
        iGo = 1'b1;
        @(negedge iCLK);
        iGo = 1'b0;
    endtask

    task automatic test_reset();
        iRST = 1'b1; iGo = 1'b0; iAbort = 1'b0; iThreshold = 32'hFFFF_FFFF;
        bus.iDone = 1'b0; bus.iScore = 32'd0;
        repeat (3) @(negedge iCLK);
        tests_run++; if ({oBusy, oDone, bus.oStart} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b want 000", {oBusy, oDone, bus.oStart}); end
        tests_run++; if ({bus.oXstart, bus.oYstart, oBestX, oBestY, oBestScore} !== 84'd0) begin tests_failed++; $display("FAIL reset_values: got x=%0d y=%0d bx=%0d by=%0d bs=%0d want all 0", bus.oXstart, bus.oYstart, oBestX, oBestY, oBestScore); end
        iRST = 1'b0;
        @(negedge iCLK);
    endtask

    task automatic test_scan();
        bit ok; logic [12:0] x, y;
        iThreshold = 32'hFFFF_FFFF;
        pulse_go();
        tests_run++; if (oBusy !== 1'b1) begin tests_failed++; $display("FAIL scan_busy: got %b want 1", oBusy); end
        for (int i = 0; i < 6; i++) begin
            wait_start(ok, x, y);
            tests_run++; if (!ok || x !== exp_x[i] || y !== exp_y[i]) begin tests_failed++; $display("FAIL scan_cand%0d: got ok=%0b (%0d,%0d) want (%0d,%0d)", i, ok, x, y, exp_x[i], exp_y[i]); end
            give_score(scores[i], 0);
        end
        wait_done(ok);
        tests_run++; if (ok !== 1'b1 || oBusy !== 1'b0) begin tests_failed++; $display("FAIL scan_done: got done=%0b busy=%0b want done=1 busy=0", ok, oBusy); end
        tests_run++; if ({oBestScore, oBestX, oBestY} !== {32'd50, 13'd4, 13'd0}) begin tests_failed++; $display("FAIL scan_best: got %0d (%0d,%0d) want 50 (4,0)", oBestScore, oBestX, oBestY); end
        repeat (3) @(negedge iCLK);
        tests_run++; if ({oDone, oBusy, oBestScore, oBestX, oBestY} !== {1'b0, 1'b0, 32'd50, 13'd4, 13'd0}) begin tests_failed++; $display("FAIL scan_hold: got done=%0b busy=%0b %0d (%0d,%0d) want 0 0 50 (4,0)", oDone, oBusy, oBestScore, oBestX, oBestY); end
    endtask

    task automatic test_abort();
        bit ok; logic [12:0] x, y; int seen;
        pulse_go();
        for (int i = 0; i < 2; i++) begin
            wait_start(ok, x, y);
            give_score(scores[i], 0);
        end
        wait_start(ok, x, y);
        tests_run++; if (!ok || x !== 13'd8 || y !== 13'd0) begin tests_failed++; $display("FAIL abort_cand3: got ok=%0b (%0d,%0d) want (8,0)", ok, x, y); end
        @(negedge iCLK);
        iAbort = 1'b1; bus.iDone = 1'b1; bus.iScore = 32'd999;
        @(negedge iCLK);
        iAbort = 1'b0; bus.iDone = 1'b0; bus.iScore = 32'd0;
        tests_run++; if ({oBusy, oDone} !== 2'b00) begin tests_failed++; $display("FAIL abort_idle: got busy=%0b done=%0b want 0 0", oBusy, oDone); end
        tests_run++; if ({oBestScore, oBestX, oBestY} !== {32'd50, 13'd4, 13'd0}) begin tests_failed++; $display("FAIL abort_best: got %0d (%0d,%0d) want 50 (4,0)", oBestScore, oBestX, oBestY); end
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            if (oDone === 1'b1 || bus.oStart === 1'b1) seen++;
            @(negedge iCLK);
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL abort_quiet: got %0d pulses want 0", seen); end
    endtask

    task automatic test_busy_go();
        bit ok; logic [12:0] x, y; int found, dones;
        pulse_go();
        found = 0;
        for (int i = 0; i < 6; i++) begin
            wait_start(ok, x, y);
            if (ok && x === exp_x[i] && y === exp_y[i]) found++;
            iGo = 1'b1;
            give_score(scores[i], 0);
        end
        iGo = 1'b0;
        tests_run++; if (found !== 6) begin tests_failed++; $display("FAIL busygo_cands: got %0d in-order candidates want 6", found); end
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            if (oDone === 1'b1) dones++;
            if (bus.oStart === 1'b1) dones += 100;
            @(negedge iCLK);
        end
        tests_run++; if (dones !== 1) begin tests_failed++; $display("FAIL busygo_done: got %0d (done + 100*extra starts) want 1", dones); end
    endtask

    task automatic test_reset_mid();
        bit ok; logic [12:0] x, y; int found;
        pulse_go();
        for (int i = 0; i < 3; i++) begin
            wait_start(ok, x, y);
            give_score(scores[i], 0);
        end
        iRST = 1'b1; iGo = 1'b1;
        @(negedge iCLK);
        tests_run++; if ({oBusy, oDone, bus.oStart, bus.oXstart, bus.oYstart, oBestX, oBestY, oBestScore} !== 87'd0) begin tests_failed++; $display("FAIL rstmid_zero: got busy=%0b x=%0d y=%0d best=%0d (%0d,%0d) want all 0", oBusy, bus.oXstart, bus.oYstart, oBestScore, oBestX, oBestY); end
        iRST = 1'b0; iGo = 1'b0;
        @(negedge iCLK);
        pulse_go();
        found = 0;
        for (int i = 0; i < 6; i++) begin
            wait_start(ok, x, y);
            if (ok && x === exp_x[i] && y === exp_y[i]) found++;
            give_score(scores[i], 0);
        end
        wait_done(ok);
        tests_run++; if (found !== 6 || !ok) begin tests_failed++; $display("FAIL rstmid_rescan: got %0d candidates done=%0b want 6 done=1", found, ok); end
        tests_run++; if ({oBestScore, oBestX, oBestY} !== {32'd50, 13'd4, 13'd0}) begin tests_failed++; $display("FAIL rstmid_best: got %0d (%0d,%0d) want 50 (4,0)", oBestScore, oBestX, oBestY); end
        @(negedge iCLK);
    endtask

    task automatic test_early_exit();
        int n, exp_n; bit done_seen;
        iThreshold = 32'd40;
`ifdef PUPIL_SEARCH_EARLY_EXIT_EN
        exp_n = 2;
`else
        exp_n = 6;
`endif
        pulse_go();
        n = 0; done_seen = 1'b0;
        for (int c = 0; c < 500 && !done_seen; c++) begin
            if (oDone === 1'b1) begin
                done_seen = 1'b1;
            end else if (bus.oStart === 1'b1 && n < 6) begin
                n++;
                give_score(scores[n-1], 0);
            end else begin
                @(negedge iCLK);
            end
        end
        tests_run++; if (!done_seen || n !== exp_n) begin tests_failed++; $display("FAIL early_exit_count: got %0d candidates done=%0b want %0d done=1", n, done_seen, exp_n); end
        tests_run++; if ({oBestScore, oBestX, oBestY} !== {32'd50, 13'd4, 13'd0}) begin tests_failed++; $display("FAIL early_exit_best: got %0d (%0d,%0d) want 50 (4,0)", oBestScore, oBestX, oBestY); end
        iThreshold = 32'hFFFF_FFFF;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic test_stall();
        bit ok; logic [12:0] x, y; int restarts, moves;
        pulse_go();
        wait_start(ok, x, y);
        @(negedge iCLK);
        restarts = 0; moves = 0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.oStart === 1'b1) restarts++;
            if (bus.oXstart !== 13'd0 || bus.oYstart !== 13'd0 || oBusy !== 1'b1) moves++;
            @(negedge iCLK);
        end
        tests_run++; if (restarts !== 0 || moves !== 0) begin tests_failed++; $display("FAIL stall_stable: got restarts=%0d changes=%0d want 0 0", restarts, moves); end
        bus.iDone = 1'b1; bus.iScore = 32'd7;
        @(negedge iCLK);
        bus.iDone = 1'b0; bus.iScore = 32'd0;
        wait_start(ok, x, y);
        tests_run++; if (!ok || x !== 13'd4 || y !== 13'd0) begin tests_failed++; $display("FAIL stall_next: got ok=%0b (%0d,%0d) want (4,0)", ok, x, y); end
        iAbort = 1'b1;
        @(negedge iCLK);
        iAbort = 1'b0;
        tests_run++; if ({oBusy, oBestScore, oBestX, oBestY} !== {1'b0, 32'd7, 13'd0, 13'd0}) begin tests_failed++; $display("FAIL stall_best: got busy=%0b %0d (%0d,%0d) want 0 7 (0,0)", oBusy, oBestScore, oBestX, oBestY); end
    endtask

    initial begin
        @(negedge iCLK);
        test_reset();
        test_scan();
        test_abort();
        test_busy_go();
        test_reset_mid();
        test_early_exit();
        test_stall();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/pupil_search_ctrl.md
PUPIL_SEARCH_CTRL -- requirements
Module: pupil_search_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- TPL_W, 64, template width.
- TPL_H, 64, template height.
- STEP, 4, candidate-position stride in both axes.
REQ-002 Ports SHALL be, as name, direction, width, meaning:
- iCLK, in, 1, sole clock; all logic is on its rising edge.
- iRST, in, 1, synchronous active-high reset.
- iGo, in, 1, start-search pulse.
- iAbort, in, 1, cancel the search in progress.
- iThreshold, in, 32, early-exit score threshold.
- oStart, out, 1, one-cycle launch pulse to the scorer.
- oXstart, out, 13, candidate window X origin.
- oYstart, out, 13, candidate window Y origin.
- iDone, in, 1, scorer-finished pulse.
- iScore, in, 32, scorer result, valid with iDone.
- oBusy, out, 1, search in progress.
- oDone, out, 1, one-cycle search-complete pulse.
- oBestX, out, 13, X origin of the best candidate.
- oBestY, out, 13, Y origin of the best candidate.
- oBestScore, out, 32, best score found.

Function
REQ-003 The FSM SHALL have the states IDLE, LAUNCH, WAIT, UPDATE and DONE.
REQ-004 IDLE: iGo=1 SHALL clear the best registers, set X=Y=0 and move to LAUNCH the next cycle; oBusy=1 from that cycle.
REQ-005 LAUNCH SHALL assert oStart for exactly one cycle with the current oXstart/oYstart, then move to WAIT.
REQ-006 oXstart/oYstart SHALL stay stable from LAUNCH until leaving UPDATE.
REQ-007 WAIT: on iDone=1, iScore SHALL be captured and the FSM SHALL move to UPDATE; WAIT SHALL have no cycle limit.
REQ-008 UPDATE: if captured score > oBestScore, or this is the first candidate, oBestScore/oBestX/oBestY SHALL load the score and the current origin.
REQ-009 Ties SHALL NOT replace the best, so the first maximum in raster order wins.
REQ-010 Raster order: X SHALL advance by STEP while X+STEP <= IMG_W-TPL_W, otherwise X=0 and Y advances by STEP.
REQ-011 After the candidate with X and Y both at their last valid values, UPDATE SHALL go to DONE instead of LAUNCH.
REQ-012 Candidate count SHALL be (floor((IMG_W-TPL_W)/STEP)+1)*(floor((IMG_H-TPL_H)/STEP)+1).
REQ-013 DONE SHALL assert oDone for one cycle, drop oBusy in the same cycle, and return to IDLE.
REQ-014 oBest* SHALL hold their values in IDLE until the next iGo.
REQ-015 iGo SHALL be ignored whenever the FSM is outside IDLE.
REQ-016 iAbort=1 in any non-IDLE state SHALL return the FSM to IDLE the next cycle, with oBusy=0, no oDone, and oBest* holding partial results.
REQ-017 iAbort SHALL take priority over iDone in the same cycle.
REQ-018 iDone outside WAIT SHALL be ignored.
REQ-019 Score comparison SHALL be unsigned 32-bit; coordinate arithmetic SHALL be 13-bit unsigned and never exceed IMG_W-TPL_W or IMG_H-TPL_H.

Reset
REQ-020 iRST=1 SHALL force IDLE and set oStart=0, oBusy=0, oDone=0, oXstart=0, oYstart=0, oBestX=0, oBestY=0 and oBestScore=0 at the next edge, including mid-search.
REQ-021 Reset SHALL take priority over iGo, iAbort and iDone.

Configuration
REQ-022 With PUPIL_SEARCH_EARLY_EXIT_EN defined, UPDATE SHALL go to DONE when the captured score >= iThreshold, with the best updated per REQ-008 first.
REQ-023 Without PUPIL_SEARCH_EARLY_EXIT_EN, iThreshold SHALL be ignored and every candidate SHALL be scanned.

Structure
REQ-024 Package pupil_search_pkg SHALL hold the FSM state encoding, the coordinate width (13) and the score width (32).
REQ-025 The X/Y stepping logic SHALL be one sub-module, pupil_pos_gen, with inputs clear/advance and outputs X, Y and last.

Verification
REQ-026 Bench parameters SHALL be IMG 16x12, TPL 8x8, STEP 4, giving 6 candidates: (0,0), (4,0), (8,0), (0,4), (4,4), (8,4).
REQ-027 Scan: scorer returns 10, 50, 30, 50, 20, 5 -> 6 oStart pulses in that order, then oDone with oBestScore=50, oBestX=4, oBestY=0 (tie kept first).
REQ-028 Abort: iAbort asserted in WAIT of the 3rd candidate -> IDLE next cycle, no oDone, oBestScore=50, oBest=(4,0).
REQ-029 Busy iGo: iGo pulsed while oBusy=1 -> no restart; still exactly 6 candidates and one oDone.
REQ-030 Reset: iRST asserted during UPDATE -> all outputs 0 next cycle; a new iGo gives a full 6-candidate scan.
REQ-031 Early exit (macro on): iThreshold=40 with scores 10, 50, ... -> oDone after the 2nd candidate, best 50 at (4,0).
REQ-032 Early exit (macro off): same stimulus -> all 6 candidates scanned.
REQ-033 Stall: iDone delayed 1000 cycles -> oStart not re-pulsed, and oXstart/oYstart stable throughout.
